// File: rtl/tinker_io_pkg.sv
// Shared word type and default sizing for the tinker_io CPU port controller.
package tinker_io_pkg;

   localparam int IO_WORD_W    = 64;
   localparam int IO_DEPTH_DEF = 8;

   typedef logic [IO_WORD_W-1:0] io_word_t;

endpackage

// File: rtl/tinker_io_if.sv
// CPU port strobes/data, host input/output handshakes and error flags of tinker_io.
interface tinker_io_if #(
   parameter int WIDTH = tinker_io_pkg::IO_WORD_W
);

   logic             in_signal;
   logic [WIDTH-1:0] in_data;
   logic             out_signal;
   logic [WIDTH-1:0] out_data;

   logic             host_in_valid;
   logic             host_in_ready;
   logic [WIDTH-1:0] host_in_data;
   logic             host_out_valid;
   logic             host_out_ready;
   logic [WIDTH-1:0] host_out_data;

   logic             overflow;
   logic             underflow;

   // master: the CPU and host side driving the port
   modport master (
      output in_signal, out_signal, out_data,
      output host_in_valid, host_in_data, host_out_ready,
      input  in_data, host_in_ready, host_out_valid, host_out_data,
      input  overflow, underflow
   );

   // slave: the tinker_io device end
   modport slave (
      input  in_signal, out_signal, out_data,
      input  host_in_valid, host_in_data, host_out_ready,
      output in_data, host_in_ready, host_out_valid, host_out_data,
      output overflow, underflow
   );

endinterface

// File: rtl/tinker_io_fifo.sv
// io_fifo: synchronous FIFO, power-of-two DEPTH; push when full only succeeds with a same-cycle pop.
module io_fifo
   import tinker_io_pkg::*;
#(
   parameter int WIDTH = IO_WORD_W,
   parameter int DEPTH = IO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset: empty masks dout and pointers restart at 0
   always_ff @(posedge clk) begin
      if (reset && do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/tinker_io.sv
// tinker_io: CPU port device end with input/output FIFOs toward the host.
// Optional sticky overflow/underflow flags built when TINKER_IO_ERR_FLAGS_EN is defined.
module tinker_io
   import tinker_io_pkg::*;
#(
   parameter int DEPTH = IO_DEPTH_DEF,
   parameter int WIDTH = IO_WORD_W
) (
   input  logic     clk,
   input  logic     reset,
   tinker_io_if.slave io
);

   logic             in_sig_q;
   logic             out_sig_q;
   logic             run_q;
   logic             rd_evt;
   logic             wr_evt;

   logic             in_push;
   logic             in_pop;
   logic             in_full;
   logic             in_empty;
   logic [$clog2(DEPTH):0] in_count;

   logic             out_push;
   logic             out_pop;
   logic             out_full;
   logic             out_empty;
   logic [$clog2(DEPTH):0] out_count;
   logic [WIDTH-1:0] out_head;

   logic             unused_counts;

   always_ff @(posedge clk) begin
      if (!reset) begin
         in_sig_q  <= 1'b0;
         out_sig_q <= 1'b0;
         run_q     <= 1'b0;
      end else begin
         in_sig_q  <= io.in_signal;
         out_sig_q <= io.out_signal;
         run_q     <= 1'b1;
      end
   end

   assign rd_evt = io.in_signal  & ~in_sig_q;
   assign wr_evt = io.out_signal & ~out_sig_q;

   // ready depends only on registered state, never on this cycle's CPU pop
   assign io.host_in_ready = run_q & ~in_full;
   assign in_push          = io.host_in_valid & io.host_in_ready;
   assign in_pop           = rd_evt & ~in_empty;

   assign io.host_out_valid = ~out_empty;
   assign io.host_out_data  = out_head;
   assign out_pop           = io.host_out_valid & io.host_out_ready;
   assign out_push          = wr_evt & (~out_full | out_pop);

   assign unused_counts = ^{in_count, out_count};

   io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push),
      .pop   (in_pop),
      .din   (io.host_in_data),
      .dout  (io.in_data),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_push),
      .pop   (out_pop),
      .din   (io.out_data),
      .dout  (out_head),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

`ifdef TINKER_IO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;
   logic wr_drop;
   logic rd_empty;

   assign wr_drop  = wr_evt & ~out_push;
   assign rd_empty = rd_evt & in_empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_drop)  overflow_q  <= 1'b1;
         if (rd_empty) underflow_q <= 1'b1;
      end
   end

   assign io.overflow  = overflow_q;
   assign io.underflow = underflow_q;
`else
   assign io.overflow  = 1'b0;
   assign io.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_tinker_io.sv
// Self-checking bench for tinker_io against a queue-based model of the port behaviour.
module tb_tinker_io;
   import tinker_io_pkg::*;

   localparam int DEPTH = IO_DEPTH_DEF;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   tinker_io_if #(.WIDTH(IO_WORD_W)) bus ();

   tinker_io #(.DEPTH(DEPTH), .WIDTH(IO_WORD_W)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   io_word_t in_q[$];
   io_word_t out_q[$];
   bit m_live, m_prev_in, m_prev_out, m_ovf, m_udf;

   function automatic io_word_t exp_in_data();
      return (in_q.size() > 0) ? in_q[0] : '0;
   endfunction

   function automatic io_word_t exp_out_data();
      return (out_q.size() > 0) ? out_q[0] : '0;
   endfunction

   function automatic bit exp_ready();
      return m_live && (in_q.size() < DEPTH);
   endfunction

   function automatic bit exp_ovf();
`ifdef TINKER_IO_ERR_FLAGS_EN
      return m_ovf;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit exp_udf();
`ifdef TINKER_IO_ERR_FLAGS_EN
      return m_udf;
`else
      return 1'b0;
`endif
   endfunction

   // advance the model by one clock using the inputs currently driven, then clock the DUT
   task automatic tick();
      bit rd, wr, hpush, hpop;
      int out_sz;
      rd    = bus.in_signal  && !m_prev_in;
      wr    = bus.out_signal && !m_prev_out;
      hpush = bus.host_in_valid && exp_ready();
      hpop  = bus.host_out_ready && (out_q.size() > 0);
      if (!reset) begin
         in_q.delete();
         out_q.delete();
         m_live = 0; m_prev_in = 0; m_prev_out = 0; m_ovf = 0; m_udf = 0;
      end else begin
         if (rd) begin
            if (in_q.size() > 0) void'(in_q.pop_front());
            else m_udf = 1;
         end
         if (hpush) in_q.push_back(bus.host_in_data);
         out_sz = out_q.size();
         if (hpop) void'(out_q.pop_front());
         if (wr) begin
            if (out_sz < DEPTH || hpop) out_q.push_back(bus.out_data);
            else m_ovf = 1;
         end
         m_prev_in  = bus.in_signal;
         m_prev_out = bus.out_signal;
         m_live     = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_signal = 0; bus.out_signal = 0; bus.out_data = '0;
      bus.host_in_valid = 0; bus.host_in_data = '0; bus.host_out_ready = 0;
   endtask

   task automatic host_push(input io_word_t w);
      bus.host_in_valid = 1; bus.host_in_data = w; tick();
      bus.host_in_valid = 0; bus.host_in_data = '0;
   endtask

   task automatic cpu_write(input io_word_t w);
      bus.out_data = w; bus.out_signal = 1; tick();
      bus.out_signal = 0; tick();
   endtask

   task automatic cpu_read_pulse();
      bus.in_signal = 1; tick();
      bus.in_signal = 0; tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 0; tick(); tick();
      checks++; if (bus.in_data !== '0) begin errors++; $display("FAIL rst_in_data got=%h exp=0", bus.in_data); end
      checks++; if (bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.host_out_valid); end
      checks++; if (bus.host_out_data !== '0) begin errors++; $display("FAIL rst_out_data got=%h exp=0", bus.host_out_data); end
      checks++; if (bus.host_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.host_in_ready); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got=%b%b exp=00", bus.overflow, bus.underflow); end
      reset = 1; tick();
      checks++; if (bus.host_in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got=%b exp=1", bus.host_in_ready); end
   endtask

   task automatic test_read_path();
      host_push(64'h1111);
      host_push(64'h2222);
      tick();
      checks++; if (bus.in_data !== 64'h1111 || exp_in_data() !== 64'h1111) begin errors++; $display("FAIL rd_head1 got=%h exp=%h", bus.in_data, 64'h1111); end
      cpu_read_pulse();
      checks++; if (bus.in_data !== 64'h2222) begin errors++; $display("FAIL rd_head2 got=%h exp=%h", bus.in_data, 64'h2222); end
      cpu_read_pulse();
      checks++; if (bus.in_data !== '0) begin errors++; $display("FAIL rd_empty_data got=%h exp=0", bus.in_data); end
      checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL rd_no_udf got=%b exp=0", bus.underflow); end
      cpu_read_pulse();
      checks++; if (bus.in_data !== '0) begin errors++; $display("FAIL udf_data got=%h exp=0", bus.in_data); end
      checks++; if (bus.underflow !== exp_udf()) begin errors++; $display("FAIL udf_set got=%b exp=%b", bus.underflow, exp_udf()); end
      tick(); tick();
      checks++; if (bus.underflow !== exp_udf()) begin errors++; $display("FAIL udf_sticky got=%b exp=%b", bus.underflow, exp_udf()); end
   endtask

   task automatic test_overflow();
      bus.host_out_ready = 0;
      for (int i = 1; i <= 9; i++) cpu_write(io_word_t'(i));
      checks++; if (bus.overflow !== exp_ovf()) begin errors++; $display("FAIL ovf_set got=%b exp=%b", bus.overflow, exp_ovf()); end
      checks++; if (bus.host_out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", bus.host_out_valid); end
      bus.host_out_ready = 1;
      for (int i = 1; i <= 8; i++) begin
         checks++;
         if (bus.host_out_data !== io_word_t'(i) || exp_out_data() !== io_word_t'(i)) begin
            errors++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.host_out_data, io_word_t'(i));
         end
         tick();
      end
      checks++; if (bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.host_out_valid); end
      bus.host_out_ready = 0;
   endtask

   task automatic test_held_strobe();
      while (in_q.size() > 0) cpu_read_pulse();
      host_push(64'hA);
      host_push(64'hB);
      host_push(64'hC);
      bus.in_signal = 1;
      repeat (4) tick();
      bus.in_signal = 0; tick();
      checks++; if (bus.in_data !== 64'hB || exp_in_data() !== 64'hB) begin errors++; $display("FAIL held_one_pop got=%h exp=%h", bus.in_data, 64'hB); end
   endtask

   task automatic test_full_pop_write();
      reset = 0; tick(); reset = 1; tick();
      bus.host_out_ready = 0;
      for (int i = 0; i < DEPTH; i++) cpu_write(io_word_t'(100 + i));
      bus.out_data = 64'h77; bus.out_signal = 1; bus.host_out_ready = 1; tick();
      bus.out_signal = 0; bus.host_out_ready = 0; tick();
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b exp=0", bus.overflow); end
      bus.host_out_ready = 1;
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (bus.host_out_valid !== 1'b1 || bus.host_out_data !== exp_out_data()) begin
            errors++; $display("FAIL fullpop_drain_%0d got=%b/%h exp=1/%h", k, bus.host_out_valid, bus.host_out_data, exp_out_data());
         end
         if (k == DEPTH-1) begin
            checks++; if (bus.host_out_data !== 64'h77) begin errors++; $display("FAIL fullpop_last got=%h exp=77", bus.host_out_data); end
         end
         tick();
      end
      checks++; if (bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_count got=%b exp=0", bus.host_out_valid); end
      bus.host_out_ready = 0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) cpu_write(io_word_t'(200 + i));
      host_push(64'h55);
      bus.host_out_ready = 1; tick();
      reset = 0; tick();
      checks++; if (bus.host_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.host_out_valid); end
      checks++; if (bus.in_data !== '0) begin errors++; $display("FAIL mid_in_data got=%h exp=0", bus.in_data); end
      checks++; if (bus.host_in_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b exp=0", bus.host_in_ready); end
      bus.host_out_ready = 0;
      reset = 1; tick();
      checks++; if (bus.host_in_ready !== 1'b1) begin errors++; $display("FAIL mid_release got=%b exp=1", bus.host_in_ready); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         bus.in_signal      = ($urandom_range(0, 2) == 0);
         bus.out_signal     = ($urandom_range(0, 2) == 0);
         bus.out_data       = {$urandom, $urandom};
         bus.host_in_valid  = ($urandom_range(0, 1) == 0);
         bus.host_in_data   = {$urandom, $urandom};
         bus.host_out_ready = ($urandom_range(0, 3) == 0);
         reset              = ($urandom_range(0, 199) != 0);
         tick();
         checks++;
         if (bus.in_data !== exp_in_data() || bus.host_in_ready !== exp_ready() ||
             bus.host_out_valid !== (out_q.size() > 0) || bus.host_out_data !== exp_out_data() ||
             bus.overflow !== exp_ovf() || bus.underflow !== exp_udf()) begin
            errors++;
            $display("FAIL rnd_cyc%0d got=%h/%b/%b/%h/%b%b exp=%h/%b/%b/%h/%b%b", c,
                     bus.in_data, bus.host_in_ready, bus.host_out_valid, bus.host_out_data, bus.overflow, bus.underflow,
                     exp_in_data(), exp_ready(), (out_q.size() > 0), exp_out_data(), exp_ovf(), exp_udf());
         end
      end
      reset = 1;
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_read_path();
      test_overflow();
      test_held_strobe();
      test_full_pop_write();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
